// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit with architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per CALC cycle,
// followed by a single FIX cycle that applies signs and writes HI/LO.
// Stalls HI/LO instructions in EX while an operation is in flight.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic             sf2reg,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Two's complement negation of a WIDTH-bit value when neg is set.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's complement negation of a double-width product when neg is set.
  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   counter;

  // Shared working register: for multiply {partial product, remaining
  // multiplier bits}; for divide {partial remainder, dividend/quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   orig_rs;   // raw dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_res;   // operand signs differ
  logic               neg_rem;   // signed dividend was negative
  logic               b_zero;    // divisor was zero

  logic is_mult_f, is_multu_f, is_div_f, is_divu_f;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_muldiv_f, is_signed_f, is_hilo_op;
  logic accept, start;

  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;
  logic rs_neg, rt_neg;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Funct decode and handshake with the hazard unit.
  always_comb begin
    is_mult_f   = (funct == F_MULT);
    is_multu_f  = (funct == F_MULTU);
    is_div_f    = (funct == F_DIV);
    is_divu_f   = (funct == F_DIVU);
    is_mfhi     = (funct == F_MFHI);
    is_mflo     = (funct == F_MFLO);
    is_mthi     = (funct == F_MTHI);
    is_mtlo     = (funct == F_MTLO);
    is_muldiv_f = is_mult_f | is_multu_f | is_div_f | is_divu_f;
    is_signed_f = is_mult_f | is_div_f;
    is_hilo_op  = is_muldiv_f | is_mfhi | is_mflo | is_mthi | is_mtlo;

    busy    = (state != S_IDLE);
    accept  = op_valid & ~busy & ~flush;
    start   = accept & is_muldiv_f;
    stall   = op_valid & busy & is_hilo_op;
    sf2reg  = op_valid & (is_mfhi | is_mflo);

    rd_data = '0;
    if (is_mfhi)      rd_data = hi;
    else if (is_mflo) rd_data = lo;
  end

  // Operand sign extraction for the signed variants.
  always_comb begin
    rs_s   = signed'(rs_val);
    rt_s   = signed'(rt_val);
    rs_neg = is_signed_f & (rs_s < 0);
    rt_neg = is_signed_f & (rt_s < 0);
  end

  // One iteration of each algorithm, selected by is_div in CALC.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb};
    if (div_diff[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod_fix = cond_neg_2w(acc, neg_res);
    if (!is_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (b_zero) begin
      fix_hi = orig_rs;
      fix_lo = '1;
    end else begin
      fix_hi = cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
      fix_lo = cond_neg_w(acc[WIDTH-1:0], neg_res);
    end
  end

  // Control state, HI/LO and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      counter  <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        counter <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (start) begin
                state    <= S_CALC;
                counter  <= CNT_W'(WIDTH);
                div_zero <= 1'b0;
              end
              if (is_mthi) hi <= rs_val;
              if (is_mtlo) lo <= rs_val;
            end
          end
          S_CALC: begin
            if (counter > CNT_W'(1)) begin
              counter <= counter - CNT_W'(1);
            end else begin
              counter <= '0;
              state   <= S_FIX;
            end
          end
          S_FIX: begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            if (is_div && b_zero) div_zero <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath: operand capture on accept, one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      is_div  <= is_div_f | is_divu_f;
      neg_res <= rs_neg ^ rt_neg;
      neg_rem <= rs_neg;
      b_zero  <= (rt_val == '0);
      orig_rs <= rs_val;
      if (is_div_f | is_divu_f) begin
        acc <= {{WIDTH{1'b0}}, cond_neg_w(rs_val, rs_neg)};
        opb <= cond_neg_w(rt_val, rt_neg);
      end else begin
        acc <= {{WIDTH{1'b0}}, cond_neg_w(rt_val, rt_neg)};
        opb <= cond_neg_w(rs_val, rs_neg);
      end
    end else if (state == S_CALC) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule
